train_scheduler: RTL and testbench
==================================

Name: train_scheduler

Overview:
- Sits directly upstream of the Axiline training controller FSM.
- Accepts a job configuration (sample count, epoch count) from the host/loader and issues one start pulse per epoch.
- Tracks per-sample progress by decoding the controller's state output and asserts done during the last sample's SGD cycle, so the controller returns to IDLE.
- Reports sample/epoch indices to the data loader and pulses completion at end of job.

Parameters:
- SAMPLE_W, 16, width of sample count/index
- EPOCH_W, 8, width of epoch count/index
- instBitwidth, 3, width of controller state code
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cfg_valid  in  1  job config valid
- cfg_ready  out  1  scheduler idle, can accept config
- cfg_num_samples  in  SAMPLE_W  samples per epoch (N)
- cfg_num_epochs  in  EPOCH_W  epochs (E)
- abort  in  1  pulse; end job after the current sample
- ctrl_inst  in  instBitwidth  controller state code
- ctrl_start  out  1  start pulse to controller
- ctrl_done  out  1  done level to controller
- sample_idx  out  SAMPLE_W  samples completed in the current epoch (COMB count)
- epoch_idx  out  EPOCH_W  current epoch, 0-based
- sample_adv  out  1  pulse when ctrl_inst==COMB
- busy  out  1  job in progress
- train_done  out  1  one-cycle pulse at end of job
- err  out  1  sticky; cfg rejected or watchdog fired

Behaviour:
- Reset (rst==0 at posedge):
  - FSM goes to S_IDLE; all counters are 0.
  - ctrl_start=0, train_done=0, err=0, busy=0, cfg_ready=1.
  - Reset wins over every other input.
- Controller codes: IDLE=0, INIT=1, INIT_IP=2, IP=3, COMB=4, PIPE=5, SGD=6.
- S_IDLE:
  - cfg_ready=1.
  - On cfg_valid:
    - If N==0 or E==0: set err, stay in S_IDLE.
    - Otherwise latch N and E, clear counters, go to S_LAUNCH.
- S_LAUNCH:
  - ctrl_start=1 for exactly this cycle.
  - Next state is S_WAIT.
- S_WAIT:
  - Wait for ctrl_inst!=IDLE, then go to S_RUN.
  - The controller normally leaves IDLE on the cycle after ctrl_start.
- S_RUN:
  - Each cycle with ctrl_inst==COMB: sample_idx+1 and sample_adv=1 (combinational from ctrl_inst, gated by S_RUN).
  - ctrl_done = S_RUN && ctrl_inst==SGD && (sample_idx==N || abort_pend).
    - Combinational, because the controller samples done during SGD.
    - COMB always precedes SGD by one cycle, so sample_idx is already incremented.
  - ctrl_done is 0 in every other state and in all other cycles.
  - When ctrl_done is asserted, go to S_DRAIN.
- S_DRAIN:
  - Wait for ctrl_inst==IDLE.
  - If abort_pend or epoch_idx==E-1: go to S_FIN.
  - Otherwise: epoch_idx+1, sample_idx=0, go to S_LAUNCH.
- S_FIN:
  - train_done=1 for one cycle, clear abort_pend, go to S_IDLE.
  - sample_idx and epoch_idx hold their final values until the next cfg accept.
- abort:
  - Sets the abort_pend register in any non-IDLE state; ignored in S_IDLE.
  - Abort in S_LAUNCH/S_WAIT: the job still completes the first sample before finishing.
- busy = state!=S_IDLE.
- Overflow: sample_idx never exceeds N, since done is forced at N. Epoch count wraps only beyond E-1, which is unreachable.
- Simultaneous cfg_valid and abort in S_IDLE: cfg is accepted, abort is ignored.
- cfg_valid outside S_IDLE: ignored (cfg_ready=0).

Optional Feature:
- Macro: TRAIN_SCHED_WATCHDOG_EN.
- Defined:
  - A TIMEOUT-cycle counter is cleared on every ctrl_inst change and on every FSM state change.
  - If it reaches TIMEOUT in S_WAIT, S_RUN or S_DRAIN: set err, pulse train_done, return to S_IDLE.
- Undefined: no counter, no timeout path; err is set only by cfg rejection.

Decomposition:
- Shared package `axiline_pkg`:
  - controller state localparams (IDLE..SGD) and their width, shared with the controller
  - scheduler FSM state encoding
- One natural sub-module, `sched_watchdog`: counter plus compare, instantiated only under the macro.

Test Plan:
- Single job, N=3, E=2, against a behavioural controller model (numCycle=8):
  - exactly 2 ctrl_start pulses
  - ctrl_done high only in the 3rd SGD cycle of each epoch
  - sample_adv pulses 3 per epoch
  - train_done one pulse after the 2nd drain; epoch_idx=1, sample_idx=3
- cfg_valid with N=0 -> err=1, busy stays 0, no ctrl_start. A following valid cfg N=1, E=1 -> done asserted in the first SGD, then train_done.
- abort pulse during the 2nd IP of an N=5, E=3 job -> ctrl_done at the next SGD (sample_idx=2), one train_done, no further ctrl_start.
- rst=0 asserted during S_RUN -> at the next edge all outputs return to reset values, cfg_ready=1; a new cfg is accepted immediately after release.
- cfg_valid held high during the run and at S_FIN -> the config is not re-latched until S_IDLE, and only then one new job starts.
- With TRAIN_SCHED_WATCHDOG_EN and TIMEOUT=16, controller model stuck in IDLE after start -> err=1 and a train_done pulse 16 cycles after entering S_WAIT.

Source files
------------

// File: rtl/axiline_pkg.sv
// Shared definitions for the Axiline training controller and the scheduler that drives it.
// Holds the controller state codes, their width, and the scheduler FSM state encoding.
package axiline_pkg;

    localparam int INST_W = 3;

    localparam logic [INST_W-1:0] INST_IDLE    = 3'd0;
    localparam logic [INST_W-1:0] INST_INIT    = 3'd1;
    localparam logic [INST_W-1:0] INST_INIT_IP = 3'd2;
    localparam logic [INST_W-1:0] INST_IP      = 3'd3;
    localparam logic [INST_W-1:0] INST_COMB    = 3'd4;
    localparam logic [INST_W-1:0] INST_PIPE    = 3'd5;
    localparam logic [INST_W-1:0] INST_SGD     = 3'd6;

    localparam int SCHED_ST_W = 3;

    localparam logic [SCHED_ST_W-1:0] S_IDLE   = 3'd0;
    localparam logic [SCHED_ST_W-1:0] S_LAUNCH = 3'd1;
    localparam logic [SCHED_ST_W-1:0] S_WAIT   = 3'd2;
    localparam logic [SCHED_ST_W-1:0] S_RUN    = 3'd3;
    localparam logic [SCHED_ST_W-1:0] S_DRAIN  = 3'd4;
    localparam logic [SCHED_ST_W-1:0] S_FIN    = 3'd5;

endpackage

// File: rtl/train_scheduler_if.sv
// Bundle between the host/loader/controller side and train_scheduler.
// master : host side (drives config, abort and the controller state code)
// slave  : train_scheduler (drives ready, controller start/done, progress and status)
interface train_scheduler_if #(
    parameter int SAMPLE_W = 16,
    parameter int EPOCH_W  = 8,
    parameter int INST_W   = 3
) ();
    logic                cfg_valid;
    logic                cfg_ready;
    logic [SAMPLE_W-1:0] cfg_num_samples;
    logic [EPOCH_W-1:0]  cfg_num_epochs;
    logic                abort;
    logic [INST_W-1:0]   ctrl_inst;
    logic                ctrl_start;
    logic                ctrl_done;
    logic [SAMPLE_W-1:0] sample_idx;
    logic [EPOCH_W-1:0]  epoch_idx;
    logic                sample_adv;
    logic                busy;
    logic                train_done;
    logic                err;

    modport master (
        output cfg_valid, cfg_num_samples, cfg_num_epochs, abort, ctrl_inst,
        input  cfg_ready, ctrl_start, ctrl_done, sample_idx, epoch_idx,
               sample_adv, busy, train_done, err
    );

    modport slave (
        input  cfg_valid, cfg_num_samples, cfg_num_epochs, abort, ctrl_inst,
        output cfg_ready, ctrl_start, ctrl_done, sample_idx, epoch_idx,
               sample_adv, busy, train_done, err
    );
endinterface

// File: rtl/train_scheduler_watchdog.sv
// sched_watchdog: progress watchdog for train_scheduler (built only with TRAIN_SCHED_WATCHDOG_EN).
// Down-counter reloaded on every controller state-code change and on every scheduler state
// change; o_fire is raised while i_active and the count has reached zero, i.e. after TIMEOUT
// cycles with no movement.
// Ports: clk, rst (sync, active-low), i_active, i_state_chg, i_inst, o_fire.
module sched_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int INST_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_active,
    input  logic              i_state_chg,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_fire
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [INST_W-1:0] r_prev_inst;
    logic              w_reload;

    assign w_reload = i_state_chg || (i_inst != r_prev_inst);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= LOAD;
            r_prev_inst <= '0;
        end else begin
            r_prev_inst <= i_inst;
            if (w_reload)
                r_cnt <= LOAD;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_fire = i_active && (r_cnt == '0);
endmodule

// File: rtl/train_scheduler.sv
// train_scheduler: sits upstream of the Axiline training controller. Accepts a job (N samples,
// E epochs), issues one ctrl_start per epoch, counts COMB cycles as completed samples and raises
// ctrl_done during the SGD cycle of the last sample (or the current one after an abort).
// Ports: clk, rst (sync, active-low), bus (train_scheduler_if.slave: cfg_*, abort, ctrl_inst in;
//        cfg_ready, ctrl_start, ctrl_done, sample_idx, epoch_idx, sample_adv, busy,
//        train_done, err out).
// Optional: define TRAIN_SCHED_WATCHDOG_EN to add a TIMEOUT-cycle stall watchdog.
//
// state    | meaning
// S_IDLE   | no job; cfg_ready=1, waiting for a config
// S_LAUNCH | one-cycle ctrl_start for the current epoch
// S_WAIT   | waiting for the controller to leave IDLE
// S_RUN    | epoch in progress; counts COMB, raises done at the final SGD
// S_DRAIN  | waiting for the controller to return to IDLE
// S_FIN    | one-cycle train_done, then back to S_IDLE
module train_scheduler
    import axiline_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int EPOCH_W      = 8,
    parameter int instBitwidth = INST_W,
    parameter int TIMEOUT      = 1024
) (
    input  logic               clk,
    input  logic               rst,
    train_scheduler_if.slave   bus
);
    logic [SCHED_ST_W-1:0] r_state;
    logic [SCHED_ST_W-1:0] w_next_state;
    logic [SAMPLE_W-1:0]   r_num_samples;
    logic [EPOCH_W-1:0]    r_num_epochs;
    logic [SAMPLE_W-1:0]   r_sample_idx;
    logic [EPOCH_W-1:0]    r_epoch_idx;
    logic                  r_abort_pend;
    logic                  r_err;

    logic w_is_idle;
    logic w_is_comb;
    logic w_is_sgd;
    logic w_cfg_ok;
    logic w_last_epoch;
    logic w_ctrl_done;
    logic w_sample_adv;
    logic w_timeout;

    assign w_is_idle    = (bus.ctrl_inst == instBitwidth'(INST_IDLE));
    assign w_is_comb    = (bus.ctrl_inst == instBitwidth'(INST_COMB));
    assign w_is_sgd     = (bus.ctrl_inst == instBitwidth'(INST_SGD));
    assign w_cfg_ok     = (bus.cfg_num_samples != '0) && (bus.cfg_num_epochs != '0);
    assign w_last_epoch = (r_epoch_idx == r_num_epochs - EPOCH_W'(1));

    // Combinational: the controller samples done in the same SGD cycle. COMB precedes SGD
    // by one cycle, so r_sample_idx already includes the sample being finished.
    assign w_ctrl_done  = (r_state == S_RUN) && w_is_sgd &&
                          ((r_sample_idx == r_num_samples) || r_abort_pend);
    assign w_sample_adv = (r_state == S_RUN) && w_is_comb;

`ifdef TRAIN_SCHED_WATCHDOG_EN
    logic w_wd_active;

    assign w_wd_active = (r_state == S_WAIT) || (r_state == S_RUN) || (r_state == S_DRAIN);

    sched_watchdog #(
        .TIMEOUT (TIMEOUT),
        .INST_W  (instBitwidth)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_active    (w_wd_active),
        .i_state_chg (w_next_state != r_state),
        .i_inst      (bus.ctrl_inst),
        .o_fire      (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.cfg_valid && w_cfg_ok) w_next_state = S_LAUNCH;
            S_LAUNCH: w_next_state = S_WAIT;
            S_WAIT:   if (!w_is_idle) w_next_state = S_RUN;
            S_RUN:    if (w_ctrl_done) w_next_state = S_DRAIN;
            S_DRAIN:  if (w_is_idle)
                          w_next_state = (r_abort_pend || w_last_epoch) ? S_FIN : S_LAUNCH;
            S_FIN:    w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        // A stall ends the job through S_FIN so the host still sees train_done.
        if (w_timeout)
            w_next_state = S_FIN;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_num_samples <= '0;
            r_num_epochs  <= '0;
            r_sample_idx  <= '0;
            r_epoch_idx   <= '0;
            r_abort_pend  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if ((r_state == S_IDLE) && bus.cfg_valid) begin
                if (w_cfg_ok) begin
                    r_num_samples <= bus.cfg_num_samples;
                    r_num_epochs  <= bus.cfg_num_epochs;
                    r_sample_idx  <= '0;
                    r_epoch_idx   <= '0;
                end else begin
                    r_err <= 1'b1;
                end
            end

            if (w_sample_adv)
                r_sample_idx <= r_sample_idx + SAMPLE_W'(1);

            if ((r_state == S_DRAIN) && (w_next_state == S_LAUNCH)) begin
                r_epoch_idx  <= r_epoch_idx + EPOCH_W'(1);
                r_sample_idx <= '0;
            end

            if (r_state == S_FIN)
                r_abort_pend <= 1'b0;
            else if (bus.abort && (r_state != S_IDLE))
                r_abort_pend <= 1'b1;

            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign bus.cfg_ready  = (r_state == S_IDLE);
    assign bus.ctrl_start = (r_state == S_LAUNCH);
    assign bus.ctrl_done  = w_ctrl_done;
    assign bus.sample_idx = r_sample_idx;
    assign bus.epoch_idx  = r_epoch_idx;
    assign bus.sample_adv = w_sample_adv;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.train_done = (r_state == S_FIN);
    assign bus.err        = r_err;
endmodule

// File: tb/tb_train_scheduler.sv
// Self-checking bench for train_scheduler. A behavioural controller model drives ctrl_inst;
// a job-level reference model (samples/epochs/abort bookkeeping in plain integers) predicts
// every output cycle by cycle.
module tb_train_scheduler;
    logic clk;
    logic rst;

    train_scheduler_if #(.SAMPLE_W(16), .EPOCH_W(8), .INST_W(3)) bus_if ();

    train_scheduler #(
        .SAMPLE_W     (16),
        .EPOCH_W      (8),
        .instBitwidth (3),
        .TIMEOUT      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // controller model
    int ci = 0;
    int ip_cnt = 0;
    int num_cycle = 8;
    bit stuck = 0;

    // job reference model
    bit m_busy, m_aborted, m_err;
    int m_N, m_E, m_samples, m_epoch;
    int exp_start_cyc, exp_tdone_cyc, done_cyc;
    int cyc = 0;
    bit model_on = 1;

    int abort_at = -1;
    bit abort_used = 0;

    int n_start, n_done, n_adv, n_tdone;

    task automatic model_reset();
        m_busy = 0; m_aborted = 0; m_err = 0;
        m_N = 0; m_E = 0; m_samples = 0; m_epoch = 0;
        exp_start_cyc = -1; exp_tdone_cyc = -1; done_cyc = -1;
    endtask

    task automatic clr_counts();
        n_start = 0; n_done = 0; n_adv = 0; n_tdone = 0;
    endtask

    task automatic cycle();
        bit e_busy, e_start, e_tdone, e_done, e_adv, s_start, s_done;
        @(negedge clk);
        s_start = bus_if.ctrl_start;
        s_done  = bus_if.ctrl_done;
        if (s_start) n_start++;
        if (s_done) n_done++;
        if (bus_if.sample_adv) n_adv++;
        if (bus_if.train_done) n_tdone++;
        e_busy  = m_busy;
        e_start = (cyc == exp_start_cyc);
        e_tdone = (cyc == exp_tdone_cyc);
        e_done  = m_busy && (ci == 6) && ((m_samples == m_N) || m_aborted);
        e_adv   = m_busy && (ci == 4);
        if (model_on) begin
            chk("busy", 32'(bus_if.busy), 32'(e_busy));
            chk("cfg_ready", 32'(bus_if.cfg_ready), 32'(!e_busy));
            chk("ctrl_start", 32'(s_start), 32'(e_start));
            chk("ctrl_done", 32'(s_done), 32'(e_done));
            chk("sample_adv", 32'(bus_if.sample_adv), 32'(e_adv));
            chk("train_done", 32'(bus_if.train_done), 32'(e_tdone));
            chk("err", 32'(bus_if.err), 32'(m_err));
            chk("sample_idx", 32'(bus_if.sample_idx), 32'(m_samples));
            chk("epoch_idx", 32'(bus_if.epoch_idx), 32'(m_epoch));
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
            ci = 0;
            ip_cnt = 0;
        end else begin
            // DRAIN decides one cycle after done, using aborts seen up to the done cycle
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                if (m_aborted || m_epoch == m_E - 1) begin
                    exp_tdone_cyc = cyc + 1;
                end else begin
                    exp_start_cyc = cyc + 1;
                    m_epoch++;
                    m_samples = 0;
                end
                done_cyc = -1;
            end
            if (e_busy && bus_if.abort) m_aborted = 1;
            if (e_tdone) begin
                m_busy = 0;
                m_aborted = 0;
            end
            if (!e_busy && bus_if.cfg_valid) begin
                if (bus_if.cfg_num_samples == 0 || bus_if.cfg_num_epochs == 0) begin
                    m_err = 1;
                end else begin
                    m_busy = 1;
                    m_N = int'(bus_if.cfg_num_samples);
                    m_E = int'(bus_if.cfg_num_epochs);
                    m_samples = 0;
                    m_epoch = 0;
                    exp_start_cyc = cyc + 1;
                end
            end
            if (e_adv) m_samples++;
            if (e_done) done_cyc = cyc;
            case (ci)
                0: if (s_start && !stuck) ci = 1;
                1: ci = 2;
                2: begin ci = 3; ip_cnt = 0; end
                3: begin ip_cnt++; if (ip_cnt >= num_cycle) ci = 4; end
                4: ci = 6;
                6: ci = s_done ? 0 : 5;
                5: begin ci = 3; ip_cnt = 0; end
                default: ci = 0;
            endcase
        end
        bus_if.ctrl_inst = 3'(ci);
        bus_if.abort = 1'b0;
        if (abort_at >= 0 && !abort_used && m_busy && ci == 3 && ip_cnt == 0 &&
            m_samples == abort_at) begin
            bus_if.abort = 1'b1;
            abort_used = 1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    task automatic run_job(input int n, input int e);
        int guard;
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_num_samples = 16'(n);
        bus_if.cfg_num_epochs = 8'(e);
        cycle();
        bus_if.cfg_valid = 1'b0;
        guard = 0;
        while (m_busy && guard < 3000) begin
            cycle();
            guard++;
        end
        chk("job_bound", 32'(m_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_num_samples = '0;
        bus_if.cfg_num_epochs = '0;
        bus_if.abort = 1'b0;
        bus_if.ctrl_inst = '0;
        model_reset();
        clr_counts();
        do_reset();
        chk("rst_ready", 32'(bus_if.cfg_ready), 32'd1);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);

        // N=3, E=2, numCycle=8
        clr_counts();
        run_job(3, 2);
        cycle();
        chk("t1_starts", 32'(n_start), 32'd2);
        chk("t1_dones", 32'(n_done), 32'd2);
        chk("t1_adv", 32'(n_adv), 32'd6);
        chk("t1_tdone", 32'(n_tdone), 32'd1);
        chk("t1_epoch", 32'(bus_if.epoch_idx), 32'd1);
        chk("t1_sample", 32'(bus_if.sample_idx), 32'd3);

        // N=0 rejected, then N=1,E=1 with a simultaneous abort (ignored in idle)
        clr_counts();
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_num_samples = 16'd0;
        bus_if.cfg_num_epochs = 8'd2;
        cycle();
        bus_if.cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t2_err", 32'(bus_if.err), 32'd1);
        chk("t2_busy", 32'(bus_if.busy), 32'd0);
        chk("t2_nostart", 32'(n_start), 32'd0);
        bus_if.abort = 1'b1;
        run_job(1, 1);
        cycle();
        chk("t2_starts", 32'(n_start), 32'd1);
        chk("t2_dones", 32'(n_done), 32'd1);
        chk("t2_tdone", 32'(n_tdone), 32'd1);

        // abort during the 2nd IP of N=5, E=3
        do_reset();
        clr_counts();
        abort_at = 1; abort_used = 0;
        run_job(5, 3);
        abort_at = -1;
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_starts", 32'(n_start), 32'd1);
        chk("t3_tdone", 32'(n_tdone), 32'd1);
        chk("t3_sample", 32'(bus_if.sample_idx), 32'd2);
        chk("t3_epoch", 32'(bus_if.epoch_idx), 32'd0);

        // reset asserted mid-run, new cfg right after release
        clr_counts();
        num_cycle = 3;
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_num_samples = 16'd4;
        bus_if.cfg_num_epochs = 8'd2;
        cycle();
        bus_if.cfg_valid = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        chk("t4_running", 32'(bus_if.busy), 32'd1);
        rst = 1'b0;
        cycle();
        cycle();
        chk("t4_rst_ready", 32'(bus_if.cfg_ready), 32'd1);
        chk("t4_rst_sample", 32'(bus_if.sample_idx), 32'd0);
        rst = 1'b1;
        clr_counts();
        run_job(2, 1);
        chk("t4_starts", 32'(n_start), 32'd1);
        chk("t4_tdone", 32'(n_tdone), 32'd1);

        // cfg_valid held through the run and S_FIN
        clr_counts();
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_num_samples = 16'd2;
        bus_if.cfg_num_epochs = 8'd2;
        cycle();
        bus_if.cfg_num_samples = 16'd1;
        bus_if.cfg_num_epochs = 8'd1;
        for (int i = 0; i < 3000 && m_busy; i++) cycle();
        chk("t5_first_epochs", 32'(n_start), 32'd2);
        cycle();
        chk("t5_reaccept", 32'(m_busy), 32'd1);
        bus_if.cfg_valid = 1'b0;
        for (int i = 0; i < 3000 && m_busy; i++) cycle();
        chk("t5_starts", 32'(n_start), 32'd3);
        chk("t5_tdone", 32'(n_tdone), 32'd2);
        chk("t5_sample", 32'(bus_if.sample_idx), 32'd1);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            int rn, re;
            rn = int'($urandom_range(1, 4));
            re = int'($urandom_range(1, 3));
            num_cycle = int'($urandom_range(1, 3));
            abort_used = 0;
            abort_at = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, rn - 1)) : -1;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) cycle();
            run_job(rn, re);
            abort_at = -1;
            cycle();
        end

`ifdef TRAIN_SCHED_WATCHDOG_EN
        begin
            int c0, td;
            do_reset();
            model_on = 0;
            stuck = 1;
            td = -1;
            bus_if.cfg_valid = 1'b1;
            bus_if.cfg_num_samples = 16'd2;
            bus_if.cfg_num_epochs = 8'd1;
            c0 = cyc;
            clr_counts();
            cycle();
            bus_if.cfg_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                cycle();
                if (n_tdone != 0 && td < 0) td = cyc - 1 - c0;
            end
            chk("wd_tdone_delay", 32'(td), 32'd18);
            chk("wd_tdone_count", 32'(n_tdone), 32'd1);
            chk("wd_err", 32'(bus_if.err), 32'd1);
            chk("wd_idle", 32'(bus_if.busy), 32'd0);
            stuck = 0;
            do_reset();
            model_on = 1;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
